ram_clear_sequencer: RTL and testbench

- Sits between the oricatmos CPU/video RAM bus (ram_ad/ram_d/ram_we/ram_cs) and port 1 of the main dpram.
- After reset and on request, sweeps the whole RAM with a power-on fill pattern while holding the CPU off.
- Then becomes a registered pass-through of the CPU bus.
- Replaces the ad-hoc reset/clr_addr register stage in the top level; clr_addr is actually advanced here.

---
 rtl/ram_clear_sequencer_pkg.sv | 19 +
 rtl/ram_clear_sequencer_fill.sv | 34 +++
 rtl/ram_clear_sequencer.sv | 151 +++++++++++++++
 tb/tb_ram_clear_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_clear_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ram_clear_sequencer_pkg
// Shared types and constants for the RAM clear sequencer.
//   state_e      : sequencer state (sweep, one-cycle finish, CPU pass-through)
//   FILL_CONST   : fill mode selecting a constant fill byte
//   FILL_STRIPE  : fill mode selecting alternating stripes of byte / ~byte
// ---------------------------------------------------------------------------
package ram_clear_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_FINISH = 2'd1,
    ST_PASS   = 2'd2
  } state_e;

  localparam int FILL_CONST  = 0;
  localparam int FILL_STRIPE = 1;

endpackage : ram_clear_sequencer_pkg

// File: rtl/ram_clear_sequencer_fill.sv
// ---------------------------------------------------------------------------
// ram_fill_pattern
// Combinational power-on fill byte for a given RAM address.
//   addr_i : address currently being cleared
//   data_o : fill byte (FILL_VALUE, or ~FILL_VALUE on odd stripes in stripe mode)
// ---------------------------------------------------------------------------
module ram_fill_pattern
  import ram_clear_sequencer_pkg::*;
#(
  parameter int          AW          = 16,
  parameter logic [7:0]  FILL_VALUE  = 8'h00,
  parameter int          FILL_MODE   = FILL_CONST,
  parameter int          STRIPE_LOG2 = 2
) (
  input  logic [AW-1:0] addr_i,
  output logic [7:0]    data_o
);

  // Only the stripe-select bit shapes the pattern; the rest of the address
  // is folded here so the full bus stays referenced.
  logic unused_addr_s;
  assign unused_addr_s = ^addr_i;

  // Select the fill byte: stripe bit set in stripe mode inverts the base byte.
  always_comb begin
    data_o = FILL_VALUE;
    if ((FILL_MODE == FILL_STRIPE) && addr_i[STRIPE_LOG2]) begin
      data_o = ~FILL_VALUE;
    end else begin
      data_o = FILL_VALUE;
    end
  end

endmodule : ram_fill_pattern

// File: rtl/ram_clear_sequencer.sv
// ---------------------------------------------------------------------------
// ram_clear_sequencer
// Sits between the CPU/video RAM bus and port 1 of the main dpram. After reset
// or a warm-clear request it sweeps every RAM byte with a fill pattern while
// holding the CPU off, then becomes a one-cycle registered pass-through.
//   clk_48, reset          : clock, asynchronous active-high reset
//   clr_req                : warm-clear request (level, sampled each clock)
//   cpu_ad/cpu_d/cpu_we/cpu_cs : CPU-side bus
//   ram_ad/ram_d/ram_we/ram_cs : registered dpram port-1 bus
//   cpu_hold               : high while the CPU bus is ignored
//   clr_busy               : high while a sweep is in progress
//   clr_done               : one-cycle pulse when a sweep completes
// All outputs are registered and describe the action taken at the last edge.
// ---------------------------------------------------------------------------
module ram_clear_sequencer
  import ram_clear_sequencer_pkg::*;
#(
  parameter int          AW          = 16,
  parameter logic [7:0]  FILL_VALUE  = 8'h00,
  parameter int          FILL_MODE   = FILL_CONST,
  parameter int          STRIPE_LOG2 = 2
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          clr_req,
  input  logic [AW-1:0] cpu_ad,
  input  logic [7:0]    cpu_d,
  input  logic          cpu_we,
  input  logic          cpu_cs,
  output logic [AW-1:0] ram_ad,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  output logic          ram_cs,
  output logic          cpu_hold,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] ram_ad_q, ram_ad_d;
  logic [7:0]    ram_d_q, ram_d_d;
  logic          ram_we_q, ram_we_d;
  logic          ram_cs_q, ram_cs_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic [7:0]    fill_byte_s;

  ram_fill_pattern #(
    .AW          (AW),
    .FILL_VALUE  (FILL_VALUE),
    .FILL_MODE   (FILL_MODE),
    .STRIPE_LOG2 (STRIPE_LOG2)
  ) u_fill (
    .addr_i (clr_addr_q),
    .data_o (fill_byte_s)
  );

  // Next-state, address counter and registered bus values for this edge.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_ad_d   = ram_ad_q;
    ram_d_d    = ram_d_q;
    ram_we_d   = 1'b0;
    ram_cs_d   = 1'b0;
    cpu_hold_d = 1'b1;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;

    if (clr_req) begin
      // A request restarts the sweep from any state; whatever access would
      // have been issued this edge is dropped so the restart is gap-defined.
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
      clr_busy_d = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_ad_d   = clr_addr_q;
          ram_d_d    = fill_byte_s;
          clr_addr_d = clr_addr_q + ADDR_ONE;
          clr_busy_d = 1'b1;
          // Terminal detect on all-ones; the counter wraps back to 0 by itself.
          if (clr_addr_q == ADDR_LAST) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_CLEAR;
          end
        end
        ST_FINISH: begin
          clr_done_d = 1'b1;
          state_d    = ST_PASS;
        end
        ST_PASS: begin
          ram_ad_d   = cpu_ad;
          ram_d_d    = cpu_d;
          ram_we_d   = cpu_we;
          ram_cs_d   = cpu_cs;
          cpu_hold_d = 1'b0;
          state_d    = ST_PASS;
        end
        default: begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          clr_busy_d = 1'b1;
        end
      endcase
    end
  end

  // State, counter and output registers; reset forces a fresh sweep from 0.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ram_ad_q   <= '0;
      ram_d_q    <= 8'h00;
      ram_we_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
      clr_busy_q <= 1'b1;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ram_ad_q   <= ram_ad_d;
      ram_d_q    <= ram_d_d;
      ram_we_q   <= ram_we_d;
      ram_cs_q   <= ram_cs_d;
      cpu_hold_q <= cpu_hold_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign ram_ad   = ram_ad_q;
  assign ram_d    = ram_d_q;
  assign ram_we   = ram_we_q;
  assign ram_cs   = ram_cs_q;
  assign cpu_hold = cpu_hold_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule : ram_clear_sequencer

// File: tb/tb_ram_clear_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ram_clear_sequencer
// Two instances share one stimulus stream: dut_a fills a constant 8'hA5,
// dut_b fills 8'h00/8'hFF stripes of four bytes. Expected RAM accesses are
// queued as stimulus is driven and popped by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_clear_sequencer;

  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] ad;
    logic [7:0]    da;
    logic [7:0]    db;
    logic          we;
  } exp_t;

  logic          clk_48 = 1'b0;
  logic          reset;
  logic          clr_req;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_d;
  logic          cpu_we;
  logic          cpu_cs;

  logic [AW-1:0] a_ad, b_ad;
  logic [7:0]    a_d, b_d;
  logic          a_we, a_cs, a_hold, a_busy, a_done;
  logic          b_we, b_cs, b_hold, b_busy, b_done;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   cyc;
  bit   found;

  always #10 clk_48 = ~clk_48;

  ram_clear_sequencer #(
    .AW(AW), .FILL_VALUE(8'hA5), .FILL_MODE(0), .STRIPE_LOG2(2)
  ) dut_a (
    .clk_48(clk_48), .reset(reset), .clr_req(clr_req),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
    .ram_ad(a_ad), .ram_d(a_d), .ram_we(a_we), .ram_cs(a_cs),
    .cpu_hold(a_hold), .clr_busy(a_busy), .clr_done(a_done)
  );

  ram_clear_sequencer #(
    .AW(AW), .FILL_VALUE(8'h00), .FILL_MODE(1), .STRIPE_LOG2(2)
  ) dut_b (
    .clk_48(clk_48), .reset(reset), .clr_req(clr_req),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
    .ram_ad(b_ad), .ram_d(b_d), .ram_we(b_we), .ram_cs(b_cs),
    .cpu_hold(b_hold), .clr_busy(b_busy), .clr_done(b_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_48);
    #1;
  endtask

  // Queue one full 16-byte sweep: A5 everywhere, stripes flip on address bit 2.
  task automatic push_sweep();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.ad = i[AW-1:0];
      e.da = 8'hA5;
      e.db = ((i / 4) % 2 == 1) ? 8'hFF : 8'h00;
      e.we = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_cpu(input logic [AW-1:0] ad, input logic [7:0] d, input logic we);
    exp_t e;
    e.ad = ad;
    e.da = d;
    e.db = d;
    e.we = we;
    sb_q.push_back(e);
  endtask

  // Wait for the completion pulse, then check the hand-over to the CPU.
  task automatic wait_done(input string tag, output int n_cyc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      step();
      n++;
      if (a_done) got = 1'b1;
    end
    n_cyc = n;
    check_eq({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check_eq({tag, "_sb_empty"}, sb_q.size(), 32'd0);
      check_eq({tag, "_done_b"}, {31'd0, b_done}, 32'd1);
      check_eq({tag, "_fin_hold"}, {31'd0, a_hold}, 32'd1);
      check_eq({tag, "_fin_busy"}, {31'd0, a_busy}, 32'd0);
      check_eq({tag, "_fin_cs"}, {31'd0, a_cs}, 32'd0);
      step();
      check_eq({tag, "_done_drop"}, {31'd0, a_done}, 32'd0);
      check_eq({tag, "_hold_drop"}, {31'd0, a_hold}, 32'd0);
    end
  endtask

  // Monitor: every access on the RAM side must match the next queued entry.
  always @(negedge clk_48) begin
    if (a_done) done_cnt++;
    if (reset) begin
      check_eq("rst_quiet", {28'd0, a_cs, a_we, b_cs, a_done}, 32'd0);
    end else if (a_cs) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("acc_ad", {28'd0, a_ad}, {28'd0, mon_e.ad});
        check_eq("acc_da", {24'd0, a_d}, {24'd0, mon_e.da});
        check_eq("acc_we", {31'd0, a_we}, {31'd0, mon_e.we});
        check_eq("acc_b_cs", {31'd0, b_cs}, 32'd1);
        check_eq("acc_b_ad", {28'd0, b_ad}, {28'd0, mon_e.ad});
        check_eq("acc_db", {24'd0, b_d}, {24'd0, mon_e.db});
      end
    end
  end

  initial begin
    logic [AW-1:0] pt_ad [4];
    logic [7:0]    pt_d  [4];
    logic          pt_we [4];
    pt_ad = '{4'h9, 4'h5, 4'hF, 4'h0};
    pt_d  = '{8'h3C, 8'hC3, 8'h11, 8'hEE};
    pt_we = '{1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; clr_req = 1'b0;
    cpu_ad = 4'h0; cpu_d = 8'h00; cpu_we = 1'b0; cpu_cs = 1'b0;
    repeat (3) step();
    check_eq("rst_cs",   {31'd0, a_cs},   32'd0);
    check_eq("rst_we",   {31'd0, a_we},   32'd0);
    check_eq("rst_ad",   {28'd0, a_ad},   32'd0);
    check_eq("rst_d",    {24'd0, a_d},    32'd0);
    check_eq("rst_hold", {31'd0, a_hold}, 32'd1);
    check_eq("rst_busy", {31'd0, a_busy}, 32'd1);
    check_eq("rst_done", {31'd0, a_done}, 32'd0);

    // Power-on sweep.
    push_sweep();
    reset = 1'b0;
    wait_done("sweep1", cyc);
    check_eq("sweep1_len", cyc, 32'd17);
    check_eq("sweep1_done_cnt", done_cnt, 32'd1);

    // Pass-through with one-clock latency, idle cycle between accesses.
    for (int i = 0; i < 4; i++) begin
      cpu_ad = pt_ad[i]; cpu_d = pt_d[i]; cpu_we = pt_we[i]; cpu_cs = 1'b1;
      push_cpu(pt_ad[i], pt_d[i], pt_we[i]);
      #2;
      check_eq("pt_pre_cs", {31'd0, a_cs}, 32'd0);
      step();
      check_eq("pt_ad", {28'd0, a_ad}, {28'd0, pt_ad[i]});
      check_eq("pt_d",  {24'd0, a_d},  {24'd0, pt_d[i]});
      check_eq("pt_we", {31'd0, a_we}, {31'd0, pt_we[i]});
      check_eq("pt_cs", {31'd0, a_cs}, 32'd1);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      step();
      check_eq("pt_idle", {30'd0, a_cs, a_we}, 32'd0);
    end

    // Warm clear while a CPU write to 2 is presented: that write is dropped.
    cpu_ad = 4'h2; cpu_d = 8'h77; cpu_we = 1'b1; cpu_cs = 1'b1; clr_req = 1'b1;
    push_sweep();
    step();
    clr_req = 1'b0; cpu_we = 1'b0; cpu_cs = 1'b0;
    check_eq("warm_drop", {30'd0, a_cs, a_we}, 32'd0);
    check_eq("warm_hold", {31'd0, a_hold}, 32'd1);
    check_eq("warm_busy", {31'd0, a_busy}, 32'd1);
    wait_done("warm", cyc);
    check_eq("warm_len", cyc, 32'd17);
    check_eq("warm_done_cnt", done_cnt, 32'd2);

    // Restart mid-sweep at address 7.
    clr_req = 1'b1;
    push_sweep();
    step();
    clr_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      if (a_cs && a_ad == 4'h7) found = 1'b1;
    end
    check_eq("restart_at7", {31'd0, found}, 32'd1);
    check_eq("restart_sb", sb_q.size(), 32'd9);
    while (sb_q.size() > 1) void'(sb_q.pop_back());
    push_sweep();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_eq("restart_gap", {31'd0, a_cs}, 32'd0);
    step();
    check_eq("restart_first_cs", {31'd0, a_cs}, 32'd1);
    check_eq("restart_first_ad", {28'd0, a_ad}, 32'd0);
    wait_done("restart", cyc);
    check_eq("restart_len", cyc, 32'd16);
    check_eq("restart_done_cnt", done_cnt, 32'd3);

    // Asynchronous reset between edges at sweep address 10.
    clr_req = 1'b1;
    push_sweep();
    step();
    clr_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      if (a_cs && a_ad == 4'hA) found = 1'b1;
    end
    check_eq("areset_at10", {31'd0, found}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_cs",   {31'd0, a_cs},   32'd0);
    check_eq("areset_we",   {31'd0, a_we},   32'd0);
    check_eq("areset_ad",   {28'd0, a_ad},   32'd0);
    check_eq("areset_hold", {31'd0, a_hold}, 32'd1);
    check_eq("areset_busy", {31'd0, a_busy}, 32'd1);
    check_eq("areset_b_cs", {31'd0, b_cs},   32'd0);
    check_eq("areset_sb", sb_q.size(), 32'd6);
    sb_q.delete();
    push_sweep();
    repeat (2) step();
    reset = 1'b0;
    wait_done("post_reset", cyc);
    check_eq("post_reset_len", cyc, 32'd17);
    check_eq("post_reset_done_cnt", done_cnt, 32'd4);

    repeat (2) step();
    check_eq("final_sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_ram_clear_sequencer
